// File: rtl/k2_load.sv
// k2_load: write-side loader for the layer-2 kernel lane memories.
// Takes a serial stream of signed weights and writes them, in the order
// kernel -> lane -> tap, into NUM_LANE per-lane memories at base(k) + tap.
module k2_load #(
    parameter int unsigned NUM_LANE = 18,
    parameter int unsigned NUM_TAP  = 25,
    parameter int unsigned MAX_KIND = 40,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned KIND_W   = 6
) (
    input  logic                clk_in,
    input  logic                rst_n,     // active-high asynchronous reset
    input  logic                start,
    input  logic [KIND_W-1:0]   num_kind,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic [NUM_LANE-1:0] wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned TapW  = (NUM_TAP > 1) ? $clog2(NUM_TAP) : 1;
    localparam int unsigned LaneW = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

    state_e            state_q;
    logic [TapW-1:0]   tap_q;
    logic [LaneW-1:0]  lane_q;
    logic [KIND_W-1:0] kind_q;
    logic [KIND_W-1:0] num_kind_q;
    logic [ADDR_W-1:0] base_q;

    logic xfer;
    logic tap_last;
    logic lane_last;
    logic kind_last;

    // Handshake and counter wrap conditions
    assign xfer      = s_valid & s_ready;
    assign tap_last  = (tap_q == TapW'(NUM_TAP - 1));
    assign lane_last = (lane_q == LaneW'(NUM_LANE - 1));
    assign kind_last = (kind_q == num_kind_q - 1'b1);

    // Session FSM with registered handshake, write port and status outputs
    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StIdle;
            tap_q      <= '0;
            lane_q     <= '0;
            kind_q     <= '0;
            num_kind_q <= '0;
            base_q     <= '0;
            s_ready    <= 1'b0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Pulses default low; wr_addr/wr_data hold between writes
            wr_en <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_kind == '0) begin
                            done <= 1'b1;
                        end else if (num_kind > KIND_W'(MAX_KIND)) begin
                            err <= 1'b1;
                        end else begin
                            num_kind_q <= num_kind;
                            tap_q      <= '0;
                            lane_q     <= '0;
                            kind_q     <= '0;
                            base_q     <= '0;
                            s_ready    <= 1'b1;
                            busy       <= 1'b1;
                            state_q    <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        wr_en   <= NUM_LANE'(1) << lane_q;
                        wr_addr <= base_q + ADDR_W'(tap_q);
                        wr_data <= s_data;
                        if (tap_last) begin
                            tap_q <= '0;
                            if (lane_last) begin
                                lane_q <= '0;
                                kind_q <= kind_q + 1'b1;
                                // Running base avoids a k*NUM_TAP multiplier
                                base_q <= base_q + ADDR_W'(NUM_TAP);
                                if (kind_last) begin
                                    s_ready <= 1'b0;
                                    done    <= 1'b1;
                                    state_q <= StFlush;
                                end
                            end else begin
                                lane_q <= lane_q + 1'b1;
                            end
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_k2_load.sv
// Self-checking bench for k2_load: randomized sessions against a word-index model.
module tb_k2_load;

    localparam int NL = 18;
    localparam int NT = 25;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic [5:0]    num_kind = '0;
    logic          s_valid = 1'b0;
    logic [15:0]   s_data  = '0;
    logic          s_ready;
    logic [NL-1:0] wr_en;
    logic [9:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;

    k2_load dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (start),
        .num_kind (num_kind),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // ---------------- behavioural model: word index n -> (k, l, t) ----------------
    int            m_phase = 0;  // 0 idle, 1 loading, 2 final write showing
    int            m_total = 0;
    int            m_n     = 0;
    logic          e_ready = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [NL-1:0] e_wr_en = '0;
    logic [9:0]    e_addr  = '0;
    logic [15:0]   e_data  = '0;

    always @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            m_phase = 0; m_total = 0; m_n = 0;
            e_ready = 0; e_busy = 0; e_done = 0; e_err = 0;
            e_wr_en = '0; e_addr = '0; e_data = '0;
        end else begin
            e_done  = 0;
            e_err   = 0;
            e_wr_en = '0;
            if (m_phase == 0) begin
                if (start) begin
                    if (num_kind == 0) e_done = 1;
                    else if (num_kind > 40) e_err = 1;
                    else begin
                        m_phase = 1; m_total = int'(num_kind) * NL * NT; m_n = 0;
                        e_busy = 1; e_ready = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (s_valid) begin
                    e_wr_en = NL'(1) << ((m_n / NT) % NL);
                    e_addr  = 10'((m_n / (NL * NT)) * NT + (m_n % NT));
                    e_data  = s_data;
                    m_n++;
                    if (m_n == m_total) begin
                        m_phase = 2; e_ready = 0; e_done = 1;
                    end
                end
            end else begin
                m_phase = 0; e_busy = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        if (!rst_n) begin
            n_checks++;
            if (s_ready !== e_ready || wr_en !== e_wr_en || wr_addr !== e_addr ||
                wr_data !== e_data || busy !== e_busy || done !== e_done || err !== e_err) begin
                $display("FAIL cycle t=%0t: got rdy=%b en=%h addr=%0d data=%h busy=%b done=%b err=%b, expected rdy=%b en=%h addr=%0d data=%h busy=%b done=%b err=%b",
                         $time, s_ready, wr_en, wr_addr, wr_data, busy, done, err,
                         e_ready, e_wr_en, e_addr, e_data, e_busy, e_done, e_err);
            end else begin
                n_pass++;
            end
        end
    end

    // ---------------- write recorder for literal pins ----------------
    logic [15:0] mem [NL][1024];
    int n_wr = 0, n_done = 0, n_err = 0, n_busy = 0, max_addr = -1;
    int first_lane = -1, first_addr = -1, first_data = -1;
    int hi_seen = 0;

    always @(negedge clk_in) begin
        if (!rst_n) begin
            if (|wr_en) begin
                int lane;
                lane = 0;
                for (int i = 0; i < NL; i++) if (wr_en[i]) lane = i;
                mem[lane][wr_addr] = wr_data;
                if (n_wr == 0) begin
                    first_lane = lane; first_addr = int'(wr_addr); first_data = int'(wr_data);
                end
                if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
                if (lane == 17 && wr_addr == 10'd999) hi_seen = 1;
                n_wr++;
            end
            if (done) n_done++;
            if (err)  n_err++;
            if (busy) n_busy++;
        end
    end

    task automatic clear_stats();
        n_wr = 0; n_done = 0; n_err = 0; n_busy = 0; max_addr = -1;
        first_lane = -1; first_addr = -1; first_data = -1; hi_seen = 0;
    endtask

    // mode 0: valid always, data = word index; 1: valid toggles, data = index;
    // 2: random valid and data. spam: random start pulses while loading.
    // abort_at > 0: return as soon as that many words have been transferred.
    task automatic session(input int nk, input int mode, input bit spam, input int abort_at);
        int idx, cyc, budget;
        bit fire, fin;
        idx = 0; cyc = 0; fin = 0;
        budget = nk * NL * NT * 4 + 20;
        @(posedge clk_in); #1;
        s_valid  = (mode == 0);
        s_data   = 16'(idx);
        start    = 1'b1;
        num_kind = 6'(nk);
        @(posedge clk_in); #1;
        start = 1'b0;
        while (!fin && cyc < budget) begin
            case (mode)
                0: s_valid = 1'b1;
                1: s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(3) != 0);
            endcase
            s_data = (mode == 2) ? 16'($urandom) : 16'(idx);
            start  = spam && ($urandom_range(19) == 0);
            @(negedge clk_in);
            fire = s_valid & s_ready;
            if (done || err) fin = 1;
            if (!fin) begin
                @(posedge clk_in); #1;
                if (fire) idx++;
                cyc++;
                if (abort_at > 0 && idx == abort_at) return;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (!fin) check("session_timeout", cyc, -1);
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    initial begin
        int bad;
        #1 rst_n = 1'b1;
        #2;
        check("rst_ready", int'(s_ready), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_addr_data", int'({wr_addr, wr_data}), 0);
        check("rst_busy_done_err", int'({busy, done, err}), 0);
        @(posedge clk_in); #3 rst_n = 1'b0;

        // one kernel, back-to-back, value = word index
        clear_stats();
        session(1, 0, 0, 0);
        check("k1_writes", n_wr, 450);
        check("k1_done", n_done, 1);
        check("k1_l5_t7", int'(mem[5][7]), 132);
        check("k1_l17_t24", int'(mem[17][24]), 449);
        bad = 0;
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < NT; t++)
                if (int'(mem[l][t]) != l * 25 + t) bad++;
        check("k1_all_words_bad", bad, 0);

        // two kernels, alternating valid
        clear_stats();
        session(2, 1, 0, 0);
        check("k2_writes", n_wr, 900);
        check("k2_l17_a49", int'(mem[17][49]), 899);
        check("k2_l0_a25", int'(mem[0][25]), 450);

        // empty and rejected sessions
        clear_stats();
        session(0, 0, 0, 0);
        check("k0_done", n_done, 1);
        check("k0_writes", n_wr, 0);
        check("k0_busy", n_busy, 0);
        clear_stats();
        session(41, 0, 0, 0);
        check("k41_err", n_err, 1);
        check("k41_writes", n_wr, 0);
        check("k41_done", n_done, 0);

        // random stream with start pulses while loading
        clear_stats();
        session(3, 2, 1, 0);
        check("k3_spam_writes", n_wr, 1350);
        check("k3_spam_done", n_done, 1);

        // abort after 100 words, then clean restart
        clear_stats();
        session(2, 0, 0, 100);
        s_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_addr_data", int'({wr_addr, wr_data}), 0);
        check("abort_status", int'({s_ready, busy, done, err}), 0);
        @(posedge clk_in); @(posedge clk_in); #3 rst_n = 1'b0;
        clear_stats();
        session(1, 0, 0, 0);
        check("restart_first_lane", first_lane, 0);
        check("restart_first_addr", first_addr, 0);
        check("restart_first_data", first_data, 0);
        check("restart_writes", n_wr, 450);

        // full capacity, random gaps and data
        clear_stats();
        session(40, 2, 0, 0);
        check("k40_writes", n_wr, 18000);
        check("k40_max_addr", max_addr, 999);
        check("k40_hi_seen", hi_seen, 1);
        check("k40_done", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
